cic_comp_fir: RTL and testbench

//  Decimate-by-2 CIC droop-compensation FIR placed directly after cic_decimator.

---
 rtl/cic_comp_pkg.sv | 24 ++
 rtl/cic_comp_mac.sv | 51 +++++
 rtl/cic_comp_fir.sv | 79 +++++++
 tb/tb_cic_comp_fir.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/cic_comp_pkg.sv
// cic_comp_pkg: shared constants, FSM encoding and coefficient table for the CIC compensation FIR
package cic_comp_pkg;
  localparam int CIC_COMP_NTAPS = 15;
  localparam int CIC_COMP_BUF_DEPTH = 32;
  localparam int CIC_COMP_CW = 16;
  localparam int CIC_COMP_DRAIN = 3;
  typedef enum logic [2:0] {IDLE, MAC, DRAIN, ROUND, OUT} state_t;
  // Symmetric Q14 droop-compensation taps, sum = 16384 for unity DC gain
  function automatic logic signed [CIC_COMP_CW-1:0] cic_comp_h(input int k);
    int m;
    m = (k < 0 || k > 14) ? -1 : (k > 7 ? 14 - k : k);
    case (m)
      0: return -16'sd20;
      1: return -16'sd10;
      2: return 16'sd60;
      3: return 16'sd40;
      4: return -16'sd300;
      5: return 16'sd400;
      6: return 16'sd4000;
      7: return 16'sd8044;
      default: return 16'sd0;
    endcase
  endfunction
endpackage

// File: rtl/cic_comp_mac.sv
// cic_comp_mac: registered multiplier, clearable accumulator and round/saturate output stage
// Ports: i_CLK/i_RST clock and async reset; clr clears acc; en marks a valid x/h pair;
//        rnd latches the rounded, saturated accumulator into y.
module cic_comp_mac #(
  parameter int IW = 18,
  parameter int CW = 16,
  parameter int OW = 16,
  parameter int SHIFT = 14
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 rnd,
  input  logic signed [IW-1:0] x,
  input  logic signed [CW-1:0] h,
  output logic signed [OW-1:0] y
);
  localparam int PW = IW + CW;
  localparam int AW = PW + 4;
  localparam logic signed [AW-1:0] HALF = AW'(1) << (SHIFT - 1);
  localparam logic signed [AW-1:0] MAXV = AW'((1 << (OW - 1)) - 1);
  localparam logic signed [AW-1:0] MINV = -MAXV - AW'(1);
  logic signed [IW-1:0] x_q;
  logic signed [CW-1:0] h_q;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc, sh;
  logic signed [OW-1:0] sat;
  logic v_q, p_v;
  // Round half toward +inf, then clamp to the output range
  assign sh = (acc + HALF) >>> SHIFT;
  assign sat = sh > MAXV ? OW'(MAXV) : sh < MINV ? OW'(MINV) : OW'(sh);
  always_ff @(posedge i_CLK or posedge i_RST)
    if (i_RST) begin
      x_q <= '0;
      h_q <= '0;
      v_q <= 1'b0;
      prod <= '0;
      p_v <= 1'b0;
      acc <= '0;
      y <= '0;
    end else begin
      x_q <= x;
      h_q <= h;
      v_q <= en;
      prod <= PW'(x_q) * PW'(h_q);
      p_v <= v_q;
      acc <= clr ? '0 : p_v ? acc + AW'(prod) : acc;
      if (rnd) y <= sat;
    end
endmodule

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: decimate-by-2 CIC droop-compensation FIR with one time-multiplexed MAC
// Ports: i_CLK clock; i_RST async active-high reset; i_DATA/i_VALID input sample strobe;
//        o_DATA/o_VALID decimated output strobe; o_BUSY sequence running; o_OVERRUN sticky drop flag.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int IW = 18,
  parameter int CW = CIC_COMP_CW,
  parameter int OW = 16,
  parameter int NTAPS = CIC_COMP_NTAPS,
  parameter int SHIFT = 14
) (
  input  logic                 i_CLK,
  input  logic                 i_RST,
  input  logic signed [IW-1:0] i_DATA,
  input  logic                 i_VALID,
  output logic signed [OW-1:0] o_DATA,
  output logic                 o_VALID,
  output logic                 o_BUSY,
  output logic                 o_OVERRUN
);
  localparam int BW = $clog2(CIC_COMP_BUF_DEPTH);
  state_t state, state_nx;
  logic signed [IW-1:0] sbuf [CIC_COMP_BUF_DEPTH];
  logic [BW-1:0] wptr, base, cnt, rd_ptr;
  logic phase, trig, start;
  logic signed [CW-1:0] coef;
  assign trig = i_VALID && phase;
  // The OUT cycle is free: a trigger there chains straight into the next MAC run
  assign start = trig && (state == IDLE || state == OUT);
  assign o_BUSY = state != IDLE;
  assign o_VALID = state == OUT;
  assign rd_ptr = base - cnt;
  assign coef = CW'(cic_comp_h(int'(cnt)));
  always_ff @(posedge i_CLK or posedge i_RST)
    if (i_RST) begin
      for (int i = 0; i < CIC_COMP_BUF_DEPTH; i++) sbuf[i] <= '0;
      wptr <= '0;
      phase <= 1'b0;
    end else if (i_VALID) begin
      sbuf[wptr] <= i_DATA;
      wptr <= wptr + 1'b1;
      phase <= ~phase;
    end
  always_ff @(posedge i_CLK or posedge i_RST)
    if (i_RST) begin
      state <= IDLE;
      cnt <= '0;
      base <= '0;
      o_OVERRUN <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state_nx == state ? cnt + 1'b1 : '0;
      if (start) base <= wptr;
      if (trig && !start) o_OVERRUN <= 1'b1;
    end
  // DRAIN covers the three pipeline stages (operand, product, accumulate)
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? MAC : IDLE;
      MAC:   state_nx = cnt == BW'(NTAPS - 1) ? DRAIN : MAC;
      DRAIN: state_nx = cnt == BW'(CIC_COMP_DRAIN - 1) ? ROUND : DRAIN;
      ROUND: state_nx = OUT;
      OUT:   state_nx = start ? MAC : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  cic_comp_mac #(.IW(IW), .CW(CW), .OW(OW), .SHIFT(SHIFT)) u_mac (
    .i_CLK(i_CLK),
    .i_RST(i_RST),
    .clr(start),
    .en(state == MAC),
    .rnd(state == ROUND),
    .x(sbuf[rd_ptr]),
    .h(coef),
    .y(o_DATA)
  );
endmodule

// File: tb/tb_cic_comp_fir.sv
// tb_cic_comp_fir: directed self-checking bench for cic_comp_fir
module tb_cic_comp_fir;
  localparam int NT = 15;
  localparam int LAT = NT + 4;
  logic i_CLK = 1'b0;
  logic i_RST = 1'b1;
  logic i_VALID = 1'b0;
  logic signed [17:0] i_DATA = '0;
  logic signed [15:0] o_DATA;
  logic o_VALID, o_BUSY, o_OVERRUN;
  int checks = 0;
  int failures = 0;
  int hist[$];
  int H[NT] = '{-20, -10, 60, 40, -300, 400, 4000, 8044, 4000, 400, -300, 40, 60, -10, -20};
  longint e;

  always #5 i_CLK = ~i_CLK;

  cic_comp_fir dut (
    .i_CLK(i_CLK),
    .i_RST(i_RST),
    .i_DATA(i_DATA),
    .i_VALID(i_VALID),
    .o_DATA(o_DATA),
    .o_VALID(o_VALID),
    .o_BUSY(o_BUSY),
    .o_OVERRUN(o_OVERRUN)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Direct convolution over the first n samples since reset, rounded and clamped
  function automatic longint model(input int n);
    longint acc = 8192;
    for (int k = 0; k < NT; k++)
      if (n - 1 - k >= 0) acc += longint'(H[k]) * longint'(hist[n - 1 - k]);
    acc = acc >>> 14;
    return acc > 32767 ? 64'sd32767 : acc < -32768 ? -64'sd32768 : acc;
  endfunction

  task automatic put(input int x);
    @(negedge i_CLK);
    i_DATA = 18'(x);
    i_VALID = 1'b1;
    hist.push_back(x);
    @(negedge i_CLK);
    i_VALID = 1'b0;
  endtask

  task automatic wait_out(input int k0, input longint exp, input string tag);
    int k = k0;
    while (!o_VALID && k < LAT + 10) begin
      @(negedge i_CLK);
      k++;
    end
    chk({tag, "_lat"}, k, LAT);
    chk({tag, "_data"}, $signed(o_DATA), exp);
  endtask

  task automatic quiet(input int n, input string tag);
    int seen = 0;
    repeat (n) begin
      @(negedge i_CLK);
      if (o_VALID) seen++;
    end
    chk(tag, seen, 0);
  endtask

  task automatic pair(input int a, input int b, input string tag);
    put(a);
    repeat (10) @(negedge i_CLK);
    put(b);
    chk({tag, "_busy"}, o_BUSY, 1);
    wait_out(0, model(hist.size()), tag);
  endtask

  task automatic do_reset();
    @(negedge i_CLK);
    i_RST = 1'b1;
    i_VALID = 1'b0;
    @(negedge i_CLK);
    i_RST = 1'b0;
    hist.delete();
  endtask

  initial begin
    repeat (2) @(negedge i_CLK);
    chk("rst_data", $signed(o_DATA), 0);
    chk("rst_valid", o_VALID, 0);
    chk("rst_busy", o_BUSY, 0);
    chk("rst_overrun", o_OVERRUN, 0);
    i_RST = 1'b0;
    put(500);
    quiet(30, "phase_single");
    put(300);
    wait_out(0, model(2), "phase_pair");
    do_reset();
    for (int j = 0; j < 9; j++) begin
      pair(0, j == 0 ? 16384 : 0, "imp");
      chk("imp_h", $signed(o_DATA), j < 8 ? H[2 * j] : 0);
    end
    do_reset();
    for (int j = 0; j < 10; j++) begin
      pair(1000, 1000, "dc");
      if (j >= 7) chk("dc_steady", $signed(o_DATA), 1000);
    end
    do_reset();
    for (int j = 0; j < 10; j++) pair(131071, 131071, "satp");
    chk("sat_pos", $signed(o_DATA), 32767);
    do_reset();
    for (int j = 0; j < 10; j++) pair(-131072, -131072, "satn");
    chk("sat_neg", $signed(o_DATA), -32768);
    do_reset();
    e = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_CLK);
      i_DATA = 18'(100 * (i + 1));
      i_VALID = 1'b1;
      hist.push_back(100 * (i + 1));
      if (i == 1) e = model(2);
    end
    @(negedge i_CLK);
    i_VALID = 1'b0;
    chk("ovr_set", o_OVERRUN, 1);
    wait_out(6, e, "ovr_first");
    quiet(30, "ovr_dropped");
    chk("ovr_sticky", o_OVERRUN, 1);
    pair(7, 9, "ovr_recover");
    chk("ovr_still", o_OVERRUN, 1);
    do_reset();
    pair(1000, 2000, "pre_rst");
    chk("pre_rst_nonzero", $signed(o_DATA) != 0, 1);
    put(3000);
    repeat (10) @(negedge i_CLK);
    put(4000);
    repeat (5) @(negedge i_CLK);
    chk("mid_busy", o_BUSY, 1);
    i_RST = 1'b1;
    #1;
    chk("mid_rst_busy", o_BUSY, 0);
    chk("mid_rst_valid", o_VALID, 0);
    chk("mid_rst_data", $signed(o_DATA), 0);
    @(negedge i_CLK);
    i_RST = 1'b0;
    hist.delete();
    quiet(30, "mid_rst_no_valid");
    put(111);
    quiet(25, "mid_rst_phase");
    put(222);
    wait_out(0, model(2), "mid_rst_first");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
